mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: LAT, default 2, memory read latency in cycles from the mem_en cycle to valid mem_rdata; legal range 1..7.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 if_req  in  1  instruction-fetch request; held high until if_done.
REQ-005 if_addr  in  16  fetch byte address (PC).
REQ-006 if_done  out  1  one-cycle pulse: fetch complete, if_rdata valid this cycle.
REQ-007 if_rdata  out  16  fetched instruction word.
REQ-008 dm_req  in  1  data-memory request; held high until dm_done.
REQ-009 dm_wr  in  1  1 = store, 0 = load; sampled at grant.
REQ-010 dm_addr  in  16  data byte address.
REQ-011 dm_wdata  in  16  store data.
REQ-012 dm_done  out  1  one-cycle pulse: data access complete, dm_rdata valid this cycle.
REQ-013 dm_rdata  out  16  load data; 0 for stores.
REQ-014 mem_en  out  1  single-port memory enable, one cycle per access.
REQ-015 mem_wr  out  1  memory write strobe, qualified by mem_en.
REQ-016 mem_addr  out  16  memory address.
REQ-017 mem_wdata  out  16  memory write data.
REQ-018 mem_rdata  in  16  memory read data, valid LAT cycles after the mem_en cycle.
REQ-019 busy  out  1  high whenever state is not IDLE.
REQ-020 err  out  1  sticky error flag, cleared only by rst.

Function
REQ-021 FSM states IDLE, FETCH, DATA; one access in flight at most.
REQ-022 In IDLE, a request is sampled at the rising edge; the winner's address, dm_wr and dm_wdata are latched and the state moves to FETCH or DATA.
REQ-023 If only one of if_req/dm_req is high, that requester is granted.
REQ-024 If both are high, the requester not granted last time wins (round-robin); the first contention after reset goes to DATA.
REQ-025 A 3-bit counter cnt clears on grant and increments each cycle in FETCH/DATA.
REQ-026 mem_en = 1 only in the cycle with cnt==0; mem_addr, mem_wr and mem_wdata carry the latched values for the whole access; mem_wr = 0 in FETCH.
REQ-027 When cnt==LAT, the granted requester's done = 1 and its rdata = mem_rdata (stores: 0); the state returns to IDLE at the next edge.
REQ-028 Latency from the request-sample edge to done is LAT+1 cycles; back-to-back throughput is one access per LAT+2 cycles.
REQ-029 Outside the done cycle, if_rdata and dm_rdata hold their last delivered value; done is never high for both requesters in one cycle.
REQ-030 A request arriving during FETCH/DATA is not sampled until IDLE.
REQ-031 err sets if the granted requester's req drops before its done.
REQ-032 err sets if a granted address has bit 0 set (unaligned word access); the access still completes.
REQ-033 In IDLE with no request, mem_en = 0 and the outputs hold.

Reset
REQ-034 rst asserted at any time, including mid-access: state = IDLE, cnt = 0, round-robin pointer = DATA-first, mem_en/mem_wr/if_done/dm_done/busy/err = 0, latched registers and rdata = 0.
REQ-035 An access interrupted by reset is abandoned; no done is issued for it after reset deasserts.

Structure
REQ-036 The state encodings (IDLE=2'b00, FETCH=2'b01, DATA=2'b10) and the LAT default belong in the shared processor include/package used by the proc datapath.
REQ-037 The state register is a separate instance of the codebase's D-flip-flop register with async reset; all other logic lives in mem_arbiter.
REQ-038 An unreachable state code (2'b11) forces IDLE and sets err.

Verification (LAT=2)
REQ-039 dm_req=1, dm_wr=0, dm_addr=0x0010 sampled at edge 0 -> mem_en=1, mem_addr=0x0010 in cycle 1; memory drives 0xBEEF; dm_done=1, dm_rdata=0xBEEF in cycle 3; busy low in cycle 4.
REQ-040 if_req and dm_req both high from reset -> DATA served first; FETCH granted in the following IDLE; second contention -> DATA again (alternation).
REQ-041 Store dm_addr=0x0020, dm_wdata=0x1234 -> a single mem_en cycle with mem_wr=1, mem_wdata=0x1234; dm_rdata=0 at dm_done.
REQ-042 rst asserted in cycle 2 of a fetch -> all outputs 0 immediately; no if_done after release; the next request completes normally.
REQ-043 Granted dm_addr=0x0011 -> err=1 and stays 1 after completion until rst; a separate test with if_req dropped mid-access -> err=1.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared processor definitions: arbiter state codes, default memory latency
// and small address helpers used by the datapath.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_DATA  = 2'b10
  } state_e;

  localparam int unsigned LAT_DEFAULT = 2;

  // Word accesses must be even-aligned; bit 0 set means a misaligned access.
  function automatic logic is_unaligned(input logic [15:0] addr);
    return addr[0];
  endfunction

endpackage

// File: rtl/mem_arbiter_dff.sv
// Generic D-flip-flop register with asynchronous active-high reset to zero.
module mem_arbiter_dff #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Plain register stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch
// and data access; one access in flight, fixed read latency LAT.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned LAT = LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_done,
  output logic [15:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic        dm_done,
  output logic [15:0] dm_rdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        busy,
  output logic        err
);

  localparam logic [2:0] LAT_C = 3'(LAT);

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] if_rdata_q, if_rdata_d;
  logic [15:0] dm_rdata_q, dm_rdata_d;
  logic        wr_q, wr_d;
  logic        prio_if_q, prio_if_d;
  logic        err_q, err_d;
  logic        req_s;

  mem_arbiter_dff #(.W(2)) u_state_reg (
    .clk (clk),
    .rst (rst),
    .d   (state_d),
    .q   (state_q)
  );

  // Access bookkeeping registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= 3'd0;
      addr_q     <= 16'h0000;
      wdata_q    <= 16'h0000;
      wr_q       <= 1'b0;
      prio_if_q  <= 1'b0;
      err_q      <= 1'b0;
      if_rdata_q <= 16'h0000;
      dm_rdata_q <= 16'h0000;
    end else begin
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      prio_if_q  <= prio_if_d;
      err_q      <= err_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  // Next-state, grant and completion logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_d       = wr_q;
    prio_if_d  = prio_if_q;
    err_d      = err_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    req_s      = 1'b0;
    mem_en     = 1'b0;
    if_done    = 1'b0;
    dm_done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // prio_if_q set means fetch lost the last grant and wins a tie.
        if (dm_req && !(if_req && prio_if_q)) begin
          state_d   = ST_DATA;
          cnt_d     = 3'd0;
          addr_d    = dm_addr;
          wr_d      = dm_wr;
          wdata_d   = dm_wdata;
          prio_if_d = 1'b1;
          err_d     = err_q | is_unaligned(dm_addr);
        end else if (if_req) begin
          state_d   = ST_FETCH;
          cnt_d     = 3'd0;
          addr_d    = if_addr;
          wr_d      = 1'b0;
          prio_if_d = 1'b0;
          err_d     = err_q | is_unaligned(if_addr);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH, ST_DATA: begin
        req_s  = (state_q == ST_FETCH) ? if_req : dm_req;
        mem_en = (cnt_q == 3'd0);
        cnt_d  = cnt_q + 3'd1;
        if (!req_s) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        if (cnt_q == LAT_C) begin
          state_d = ST_IDLE;
          if (state_q == ST_FETCH) begin
            if_done    = 1'b1;
            if_rdata_d = mem_rdata;
          end else begin
            dm_done    = 1'b1;
            dm_rdata_d = wr_q ? 16'h0000 : mem_rdata;
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        err_d   = 1'b1;
      end
    endcase
  end

  // The _d values equal the held _q values outside the done cycle.
  assign if_rdata  = if_rdata_d;
  assign dm_rdata  = dm_rdata_d;
  assign mem_wr    = wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != ST_IDLE);
  assign err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, multi-cycle corner sequences,
// and randomized transactions checked against a transaction-level memory model.
module tb_mem_arbiter;

  localparam int LAT = 2;

  logic        clk, rst;
  logic        if_req, dm_req, dm_wr;
  logic [15:0] if_addr, dm_addr, dm_wdata;
  logic        if_done, dm_done, mem_en, mem_wr, busy, err;
  logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_done(dm_done), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory device: 256 word slots, unwritten words read as addr ^ 0x5A3C,
  // reset image holds 0xBEEF at byte address 0x0010.
  logic [15:0] dev_mem [0:255];
  logic        dev_vld [0:255];
  logic [15:0] rd_pipe [0:7];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) dev_vld[i] <= 1'b0;
      dev_vld[8] <= 1'b1;
      dev_mem[8] <= 16'hBEEF;
    end else if (mem_en && mem_wr) begin
      dev_vld[mem_addr[8:1]] <= 1'b1;
      dev_mem[mem_addr[8:1]] <= mem_wdata;
    end
    rd_pipe[0] <= (mem_en && !mem_wr) ?
                  (dev_vld[mem_addr[8:1]] ? dev_mem[mem_addr[8:1]] : (mem_addr ^ 16'h5A3C)) :
                  16'hDEAD;
    for (int i = 1; i < 8; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  // Reference model: word store map plus round-robin expectation.
  logic [15:0] ref_mem [logic [15:0]];
  logic        next_dm_wins;

  function automatic logic [15:0] ref_read(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : (a ^ 16'h5A3C);
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; if_req = 1'b0; dm_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 16'd0);
    chk("rst_err", err, 16'd0);
    chk("rst_mem_en", mem_en, 16'd0);
    chk("rst_rdata", {if_rdata | dm_rdata}, 16'h0000);
    rst = 1'b0;
  endtask

  // One arbitration round starting at a negedge with the DUT idle.
  task automatic run_txn(input logic ui, input logic ud, input logic [15:0] ia,
                         input logic [15:0] da, input logic dwr, input logic [15:0] dwd,
                         input logic exp_dm_first, input logic [15:0] exp_ird,
                         input logic [15:0] exp_drd, input logic exp_err);
    int t_if, t_dm, t_last;
    logic both, first_dm, is_dm;
    both     = ui && ud;
    first_dm = both ? exp_dm_first : ud;
    t_if = 0; t_dm = 0;
    if (both) begin
      t_dm = first_dm ? LAT + 1 : 2*LAT + 3;
      t_if = first_dm ? 2*LAT + 3 : LAT + 1;
    end else if (ui) begin
      t_if = LAT + 1;
    end else begin
      t_dm = LAT + 1;
    end
    t_last = both ? 2*LAT + 3 : LAT + 1;
    if_req = ui; if_addr = ia;
    dm_req = ud; dm_addr = da; dm_wr = dwr; dm_wdata = dwd;
    for (int k = 1; k <= t_last + 1; k++) begin
      @(negedge clk);
      if (k == t_if + 1) if_req = 1'b0;
      if (k == t_dm + 1) dm_req = 1'b0;
      chk("if_done", if_done, 16'(k == t_if));
      chk("dm_done", dm_done, 16'(k == t_dm));
      chk("mem_en", mem_en, 16'(k == 1 || (both && k == LAT + 3)));
      chk("busy", busy, 16'(k <= LAT + 1 || (both && k >= LAT + 3 && k <= t_last)));
      if (k == t_if) chk("if_rdata", if_rdata, exp_ird);
      if (k == t_dm) chk("dm_rdata", dm_rdata, exp_drd);
      if (k == 1 || (both && k == LAT + 3)) begin
        is_dm = (k == 1) ? first_dm : !first_dm;
        chk("mem_addr", mem_addr, is_dm ? da : ia);
        chk("mem_wr", mem_wr, 16'(is_dm && dwr));
        if (is_dm && dwr) chk("mem_wdata", mem_wdata, dwd);
      end
    end
    if (ui) chk("if_rdata_hold", if_rdata, exp_ird);
    if (ud) chk("dm_rdata_hold", dm_rdata, exp_drd);
    chk("err", err, 16'(exp_err));
  endtask

  typedef struct {
    logic        ui, ud;
    logic [15:0] ia, da;
    logic        dwr;
    logic [15:0] dwd;
    logic        dm_first;
    logic [15:0] ird, drd;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_wr = 1'b0;
    if_addr = 16'h0000; dm_addr = 16'h0000; dm_wdata = 16'h0000;

    tbl[0] = '{1'b0, 1'b1, 16'h0000, 16'h0010, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'hBEEF};
    tbl[1] = '{1'b0, 1'b1, 16'h0000, 16'h0020, 1'b1, 16'h1234, 1'b1, 16'h0000, 16'h0000};
    tbl[2] = '{1'b1, 1'b1, 16'h0100, 16'h0020, 1'b0, 16'h0000, 1'b0, 16'h5B3C, 16'h1234};
    tbl[3] = '{1'b1, 1'b0, 16'h0102, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h5B3E, 16'h0000};
    tbl[4] = '{1'b1, 1'b1, 16'h0104, 16'h0040, 1'b0, 16'h0000, 1'b1, 16'h5B38, 16'h5A7C};
    tbl[5] = '{1'b0, 1'b1, 16'h0000, 16'h0030, 1'b1, 16'hCAFE, 1'b1, 16'h0000, 16'h0000};
    tbl[6] = '{1'b1, 1'b1, 16'h0106, 16'h0030, 1'b0, 16'h0000, 1'b0, 16'h5B3A, 16'hCAFE};

    do_reset();
    chk("idle_mem_addr", mem_addr, 16'h0000);
    chk("idle_mem_wr", mem_wr, 16'd0);
    for (int i = 0; i < 7; i++)
      run_txn(tbl[i].ui, tbl[i].ud, tbl[i].ia, tbl[i].da, tbl[i].dwr, tbl[i].dwd,
              tbl[i].dm_first, tbl[i].ird, tbl[i].drd, 1'b0);

    // Randomized rounds; the first two are contentions straight after reset.
    do_reset();
    ref_mem.delete();
    next_dm_wins = 1'b1;
    for (int i = 0; i < 40; i++) begin
      int          mode;
      logic        ui, ud, w, dmf;
      logic [15:0] ia, da, wd, erd_i, erd_d;
      mode  = (i < 2) ? 2 : int'($urandom_range(0, 2));
      ia    = 16'h1100 + 16'(2 * $urandom_range(0, 63));
      da    = 16'h2040 + 16'(2 * $urandom_range(0, 15));
      w     = 1'($urandom_range(0, 1));
      wd    = 16'($urandom);
      ui    = (mode != 1);
      ud    = (mode != 0);
      dmf   = (mode == 2) ? next_dm_wins : ud;
      erd_i = ref_read(ia);
      erd_d = w ? 16'h0000 : ref_read(da);
      if (ud && w) ref_mem[da] = wd;
      if (mode == 0) next_dm_wins = 1'b1;
      else if (mode == 1) next_dm_wins = 1'b0;
      else next_dm_wins = dmf;
      run_txn(ui, ud, ia, da, w, wd, dmf, erd_i, erd_d, 1'b0);
    end

    // Reset in the second cycle of a fetch abandons it.
    do_reset();
    if_req = 1'b1; if_addr = 16'h0200;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 16'd0);
    chk("midrst_mem_en", mem_en, 16'd0);
    chk("midrst_if_done", if_done, 16'd0);
    chk("midrst_mem_addr", mem_addr, 16'h0000);
    chk("midrst_if_rdata", if_rdata, 16'h0000);
    @(negedge clk);
    rst = 1'b0; if_req = 1'b0;
    for (int k = 0; k < LAT + 3; k++) begin
      @(negedge clk);
      chk("abandon_if_done", if_done, 16'd0);
      chk("abandon_busy", busy, 16'd0);
    end
    run_txn(1'b1, 1'b0, 16'h0202, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h583E, 16'h0000, 1'b0);

    // Unaligned data address: access completes, err sticks until reset.
    do_reset();
    run_txn(1'b0, 1'b1, 16'h0000, 16'h0011, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'hBEEF, 1'b1);
    repeat (3) @(negedge clk);
    chk("err_sticky", err, 16'd1);
    run_txn(1'b1, 1'b0, 16'h0104, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h5B38, 16'h0000, 1'b1);

    // Requester withdrawing mid-access flags an error.
    do_reset();
    if_req = 1'b1; if_addr = 16'h0300;
    @(negedge clk);
    if_req = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    chk("err_req_drop", err, 16'd1);
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
